acc_alu: RTL and testbench

//  Accumulator/backup register stage of a TIS-100 execution node. Accepts one
//  ALU op per handshake and forms a raw 12-bit signed result on raw_out.
//  raw_out feeds the downstream saturating clamp (range [-999,999]).
//  The clamped 11-bit value returns on sat_in and is written into ACC.

---
 rtl/acc_alu_if.sv | 23 ++
 rtl/acc_alu.sv | 81 ++++++++
 tb/tb_acc_alu.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/acc_alu_if.sv
// acc_alu_if: op handshake, clamp loop and status bus between the sequencer and the accumulator stage.
interface acc_alu_if #(parameter int DATA_W = 11);
  logic                     op_valid;
  logic                     op_ready;
  logic [2:0]               op_code;
  logic signed [DATA_W-1:0] operand;
  logic signed [DATA_W:0]   raw_out;
  logic signed [DATA_W-1:0] sat_in;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] bak;
  logic                     done;
  logic                     flag_z;
  logic                     flag_n;
  logic                     sat_flag;
  modport slave (
    input  op_valid, op_code, operand, sat_in,
    output op_ready, raw_out, acc, bak, done, flag_z, flag_n, sat_flag
  );
  modport master (
    output op_valid, op_code, operand, sat_in,
    input  op_ready, raw_out, acc, bak, done, flag_z, flag_n, sat_flag
  );
endinterface

// File: rtl/acc_alu.sv
// acc_alu: TIS-100 ACC/BAK stage; forms an unclamped raw result and writes the clamped return into ACC.
// Optional sticky saturation flag enabled by defining ACC_SAT_FLAG_EN.
module acc_alu #(
  parameter int                       DATA_W    = 11,
  parameter logic signed [DATA_W-1:0] ACC_RESET = '0
) (
  input logic      clk,
  input logic      rst_n,
  acc_alu_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_SWP = 3'd5;
  localparam logic [2:0] OP_SAV = 3'd6;
  logic [0:0]               r_state;
  logic [2:0]               r_op;
  logic signed [DATA_W:0]   r_raw;
  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] r_bak;
  logic                     r_done;
  logic signed [DATA_W:0]   w_acc_x;
  logic signed [DATA_W:0]   w_opd_x;
  logic signed [DATA_W:0]   w_raw;
  logic                     w_arith;
  assign w_acc_x = {r_acc[DATA_W-1], r_acc};
  assign w_opd_x = {bus.operand[DATA_W-1], bus.operand};
  always_comb begin
    w_raw = bus.op_code == OP_MOV ? w_opd_x :
            bus.op_code == OP_ADD ? w_acc_x + w_opd_x :
            bus.op_code == OP_SUB ? w_acc_x - w_opd_x :
            bus.op_code == OP_NEG ? -w_acc_x : w_acc_x;
  end
  assign w_arith = r_op inside {OP_MOV, OP_ADD, OP_SUB, OP_NEG};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_raw   <= '0;
      r_acc   <= ACC_RESET;
      r_bak   <= ACC_RESET;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_state == S_EXEC;
      if (r_state == S_IDLE && bus.op_valid) begin
        r_state <= S_EXEC;
        r_op    <= bus.op_code;
        r_raw   <= w_raw;
      end else if (r_state == S_EXEC) begin
        r_state <= S_IDLE;
        r_acc   <= w_arith ? bus.sat_in : (r_op == OP_SWP ? r_bak : r_acc);
        r_bak   <= (r_op == OP_SWP || r_op == OP_SAV) ? r_acc : r_bak;
      end
    end
  end
`ifdef ACC_SAT_FLAG_EN
  localparam logic signed [DATA_W:0] LIM = (DATA_W+1)'(999);
  logic r_sat;
  logic w_sat_hit;
  // Clamp disagreement or an out-of-range raw value both count as saturation.
  assign w_sat_hit = bus.sat_in != r_raw[DATA_W-1:0] || r_raw > LIM || r_raw < -LIM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sat <= 1'b0;
    else if (r_state == S_EXEC && w_arith && w_sat_hit) r_sat <= 1'b1;
  end
  assign bus.sat_flag = r_sat;
`else
  assign bus.sat_flag = 1'b0;
`endif
  assign bus.op_ready = r_state == S_IDLE;
  assign bus.raw_out  = r_raw;
  assign bus.acc      = r_acc;
  assign bus.bak      = r_bak;
  assign bus.done     = r_done;
  assign bus.flag_z   = r_acc == '0;
  assign bus.flag_n   = r_acc[DATA_W-1];
endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: random and directed ops against an integer ACC/BAK model with a behavioural clamp stage.
module tb_acc_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int acc_m = 0;
  int bak_m = 0;
  int sat_m = 0;
  acc_alu_if #(.DATA_W(11)) bus ();
  acc_alu #(.DATA_W(11), .ACC_RESET('0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic int clamp(int v);
    return v > 999 ? 999 : (v < -999 ? -999 : v);
  endfunction
  always_comb bus.sat_in = 11'(clamp(int'(bus.raw_out)));
  function automatic bit arith(int c);
    return c >= 1 && c <= 4;
  endfunction
  function automatic int model_raw(int c, int v);
    return c == 1 ? v : c == 2 ? acc_m + v : c == 3 ? acc_m - v : c == 4 ? -acc_m : acc_m;
  endfunction
  task automatic check_state(string tag);
    total++;
    if (int'(bus.acc) !== acc_m) begin bad++; $display("FAIL %s acc got=%0d exp=%0d", tag, int'(bus.acc), acc_m); end
    total++;
    if (int'(bus.bak) !== bak_m) begin bad++; $display("FAIL %s bak got=%0d exp=%0d", tag, int'(bus.bak), bak_m); end
    total++;
    if (bus.flag_z !== (acc_m == 0) || bus.flag_n !== (acc_m < 0)) begin
      bad++; $display("FAIL %s flags z/n got=%b%b exp=%b%b", tag, bus.flag_z, bus.flag_n, acc_m == 0, acc_m < 0);
    end
    total++;
`ifdef ACC_SAT_FLAG_EN
    if (bus.sat_flag !== sat_m[0]) begin bad++; $display("FAIL %s sat_flag got=%b exp=%b", tag, bus.sat_flag, sat_m[0]); end
`else
    if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL %s sat_flag got=%b exp=0", tag, bus.sat_flag); end
`endif
  endtask
  task automatic do_op(int c, int v);
    int raw;
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.op_ready && n < 10) begin @(negedge clk); n++; end
    total++;
    if (!bus.op_ready) begin bad++; $display("FAIL ready_timeout op_ready got=0 exp=1"); end
    bus.op_valid = 1'b1;
    bus.op_code = 3'(c);
    bus.operand = 11'(v);
    raw = model_raw(c, v);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    total++;
    if (int'(bus.raw_out) !== raw || bus.done !== 1'b0) begin
      bad++; $display("FAIL raw op=%0d raw_out got=%0d exp=%0d done=%b", c, int'(bus.raw_out), raw, bus.done);
    end
    if (arith(c)) begin
      if (raw > 999 || raw < -999) sat_m = 1;
      acc_m = clamp(raw);
    end else if (c == 5) begin
      n = acc_m; acc_m = bak_m; bak_m = n;
    end else if (c == 6) bak_m = acc_m;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL done op=%0d got=%b exp=1", c, bus.done); end
    check_state("retire");
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    acc_m = 0; bak_m = 0; sat_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.operand = '0;
    do_reset();
    #1;
    total++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0 || bus.raw_out !== 12'd0) begin
      bad++; $display("FAIL reset ready/done/raw got=%b/%b/%0d exp=1/0/0", bus.op_ready, bus.done, int'(bus.raw_out));
    end
    check_state("reset");
  endtask
  task automatic test_saturate();
    do_op(1, 500);
    do_op(2, 600);
    total++;
    if (int'(bus.acc) !== 999) begin bad++; $display("FAIL sat_pos acc got=%0d exp=999", int'(bus.acc)); end
    do_op(1, -999);
    do_op(3, 999);
    total++;
    if (int'(bus.acc) !== -999 || bus.flag_n !== 1'b1) begin
      bad++; $display("FAIL sat_neg acc got=%0d flag_n=%b exp=-999 1", int'(bus.acc), bus.flag_n);
    end
    do_op(1, 1023);
  endtask
  task automatic test_swap();
    do_op(1, 42);
    do_op(6, 0);
    do_op(1, 7);
    do_op(5, 0);
    total++;
    if (int'(bus.acc) !== 42 || int'(bus.bak) !== 7) begin
      bad++; $display("FAIL swap acc/bak got=%0d/%0d exp=42/7", int'(bus.acc), int'(bus.bak));
    end
    do_op(4, 0);
    do_op(7, 300);
    do_op(0, -5);
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++) do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)) - 1024);
  endtask
  task automatic test_back_to_back();
    int acc_cnt;
    int done_cnt;
    do_reset();
    acc_cnt = 0; done_cnt = 0;
    bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.operand = 11'd1;
    for (int i = 0; i < 6; i++) begin
      if (bus.op_ready) acc_cnt++;
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    if (bus.done) done_cnt++;
    acc_m = 3;
    total++;
    if (acc_cnt !== 3 || done_cnt !== 3) begin
      bad++; $display("FAIL back_to_back accepts/dones got=%0d/%0d exp=3/3", acc_cnt, done_cnt);
    end
    repeat (2) @(negedge clk);
    check_state("back_to_back");
  endtask
  task automatic test_reset_mid();
    int dn;
    do_op(1, 10);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.operand = 11'd5;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    total++;
    if (bus.op_ready !== 1'b0 || int'(bus.raw_out) !== 15) begin
      bad++; $display("FAIL mid_exec ready/raw got=%b/%0d exp=0/15", bus.op_ready, int'(bus.raw_out));
    end
    #2;
    rst_n = 1'b0;
    #1;
    acc_m = 0; bak_m = 0; sat_m = 0;
    check_state("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (4) begin @(negedge clk); if (bus.done) dn++; end
    total++;
    if (dn !== 0 || bus.op_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset done_pulses/ready got=%0d/%b exp=0/1", dn, bus.op_ready);
    end
    check_state("mid_reset_after");
    do_op(2, 1);
  endtask
  initial begin
    test_reset();
    test_saturate();
    test_swap();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
